udp_echo_buffered: RTL and testbench

Store-and-forward UDP echo endpoint for a single UDP port, the parametrised successor to the fixed single-port loopback. It sits on one channel of the UDP switch and accepts a complete datagram into an internal byte buffer. It validates the datagram (port match, error flag, size limit, enable), then returns it to the sender with swapped addressing and a recomputed UDP length. Frames that fail validation are drained and counted.

---
 rtl/udp_echo_buffered.sv | 242 ++++++++++++++++++++++++
 tb/tb_udp_echo_buffered.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_echo_buffered.sv
// rtl/udp_echo_buffered.sv - store-and-forward UDP echo endpoint with payload buffer
module udp_echo_buffered #(
   parameter int UDP_PORT     = 1230,
   parameter int BUFFER_BYTES = 2048,
   parameter int TTL          = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] local_ip,
   input  logic        echo_enable,
   // received header
   input  logic        rx_hdr_valid,
   output logic        rx_hdr_ready,
   input  logic [31:0] rx_hdr_ip_source_ip,
   input  logic [15:0] rx_hdr_source_port,
   input  logic [15:0] rx_hdr_dest_port,
   input  logic [15:0] rx_hdr_length,
   // received payload
   input  logic [7:0]  rx_payload_tdata,
   input  logic        rx_payload_tvalid,
   output logic        rx_payload_tready,
   input  logic        rx_payload_tlast,
   input  logic        rx_payload_tuser,
   // echoed header
   output logic        tx_hdr_valid,
   input  logic        tx_hdr_ready,
   output logic [31:0] tx_hdr_ip_source_ip,
   output logic [31:0] tx_hdr_ip_dest_ip,
   output logic [7:0]  tx_hdr_ip_ttl,
   output logic [5:0]  tx_hdr_ip_dscp,
   output logic [1:0]  tx_hdr_ip_ecn,
   output logic [15:0] tx_hdr_source_port,
   output logic [15:0] tx_hdr_dest_port,
   output logic [15:0] tx_hdr_length,
   output logic [15:0] tx_hdr_checksum,
   // echoed payload
   output logic [7:0]  tx_payload_tdata,
   output logic        tx_payload_tvalid,
   input  logic        tx_payload_tready,
   output logic        tx_payload_tlast,
   output logic        tx_payload_tuser,
   // statistics
   output logic [31:0] echo_count,
   output logic [31:0] drop_count
);

   localparam int AW = $clog2(BUFFER_BYTES);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {IDLE, RX_PAYLOAD, DROP, TX_HEADER, TX_PAYLOAD} state_t;

   state_t          state;
   logic [31:0]     src_ip;
   logic [15:0]     src_port;
   logic [CW-1:0]   count;
   logic [CW-1:0]   rd_ptr;
   logic            pend;
   logic            pend_last;
   logic            skid_valid;
   logic [7:0]      skid_data;
   logic            skid_last;

   logic [7:0]      mem [BUFFER_BYTES];
   logic [7:0]      ram_q;

   logic            pop;
   logic [2:0]      occ_after;
   logic            hdr_issue;
   logic            rd_issue;
   logic            rd_en;
   logic [AW-1:0]   rd_addr;
   logic            rx_beat;
   logic            overflow;
   logic            wr_en;
   logic            unused_rx_length;

   // The received length is implied by tlast; it is not needed for the echo.
   assign unused_rx_length = ^rx_hdr_length;

   assign tx_hdr_ip_dscp   = 6'd0;
   assign tx_hdr_ip_ecn    = 2'd0;
   assign tx_hdr_checksum  = 16'd0;
   assign tx_payload_tuser = 1'b0;

   // Buffer write/read enables and the read-issue decision for the replay pipeline.
   // Reads are issued only when the output register, skid register and the read in
   // flight can all be absorbed, so no byte ever has to be dropped or re-read.
   always_comb begin
      pop       = tx_payload_tvalid && tx_payload_tready;
      occ_after = {2'b00, tx_payload_tvalid} + {2'b00, skid_valid} + {2'b00, pend} - {2'b00, pop};
      hdr_issue = (state == TX_HEADER) && tx_hdr_valid && tx_hdr_ready;
      rd_issue  = (state == TX_PAYLOAD) && (rd_ptr < count) && (occ_after <= 3'd1);
      rd_en     = hdr_issue || rd_issue;
      rd_addr   = hdr_issue ? '0 : rd_ptr[AW-1:0];
      rx_beat   = rx_payload_tvalid && rx_payload_tready;
      overflow  = (state == RX_PAYLOAD) && rx_beat && !rx_payload_tlast
                  && (count == CW'(BUFFER_BYTES - 1));
      wr_en     = (state == RX_PAYLOAD) && rx_beat && !overflow;
   end

   // Payload RAM: one write port from rx, one synchronous read port for replay.
   always_ff @(posedge clk) begin
      if (wr_en) mem[count[AW-1:0]] <= rx_payload_tdata;
      if (rd_en) ram_q <= mem[rd_addr];
   end

   // Main control: receive, validate, then replay with swapped addressing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state               <= IDLE;
         rx_hdr_ready        <= 1'b0;
         rx_payload_tready   <= 1'b0;
         tx_hdr_valid        <= 1'b0;
         tx_hdr_ip_source_ip <= '0;
         tx_hdr_ip_dest_ip   <= '0;
         tx_hdr_ip_ttl       <= '0;
         tx_hdr_source_port  <= '0;
         tx_hdr_dest_port    <= '0;
         tx_hdr_length       <= '0;
         tx_payload_tdata    <= '0;
         tx_payload_tvalid   <= 1'b0;
         tx_payload_tlast    <= 1'b0;
         echo_count          <= '0;
         drop_count          <= '0;
         src_ip              <= '0;
         src_port            <= '0;
         count               <= '0;
         rd_ptr              <= '0;
         pend                <= 1'b0;
         pend_last           <= 1'b0;
         skid_valid          <= 1'b0;
         skid_data           <= '0;
         skid_last           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rx_hdr_ready <= 1'b1;
               if (rx_hdr_valid && rx_hdr_ready) begin
                  rx_hdr_ready      <= 1'b0;
                  rx_payload_tready <= 1'b1;
                  src_ip            <= rx_hdr_ip_source_ip;
                  src_port          <= rx_hdr_source_port;
                  count             <= '0;
                  if ((rx_hdr_dest_port == 16'(UDP_PORT)) && echo_enable)
                     state <= RX_PAYLOAD;
                  else
                     state <= DROP;
               end
            end
            RX_PAYLOAD: begin
               if (rx_beat) begin
                  if (rx_payload_tlast) begin
                     rx_payload_tready <= 1'b0;
                     count             <= count + 1'b1;
                     if (rx_payload_tuser) begin
                        drop_count   <= drop_count + 1;
                        rx_hdr_ready <= 1'b1;
                        state        <= IDLE;
                     end else begin
                        tx_hdr_valid        <= 1'b1;
                        tx_hdr_ip_source_ip <= local_ip;
                        tx_hdr_ip_dest_ip   <= src_ip;
                        tx_hdr_ip_ttl       <= 8'(TTL);
                        tx_hdr_source_port  <= 16'(UDP_PORT);
                        tx_hdr_dest_port    <= src_port;
                        tx_hdr_length       <= 16'(count) + 16'd9;
                        state               <= TX_HEADER;
                     end
                  end else if (overflow) begin
                     state <= DROP;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            DROP: begin
               if (rx_beat && rx_payload_tlast) begin
                  rx_payload_tready <= 1'b0;
                  drop_count        <= drop_count + 1;
                  rx_hdr_ready      <= 1'b1;
                  state             <= IDLE;
               end
            end
            TX_HEADER: begin
               // byte 0 is fetched on the handshake so the first beat is not delayed
               if (hdr_issue) begin
                  tx_hdr_valid <= 1'b0;
                  rd_ptr       <= CW'(1);
                  pend         <= 1'b1;
                  pend_last    <= (count == CW'(1));
                  skid_valid   <= 1'b0;
                  state        <= TX_PAYLOAD;
               end
            end
            TX_PAYLOAD: begin
               pend <= rd_issue;
               if (rd_issue) begin
                  rd_ptr    <= rd_ptr + 1'b1;
                  pend_last <= (rd_ptr == count - 1'b1);
               end
               if (pop) begin
                  if (skid_valid) begin
                     tx_payload_tdata <= skid_data;
                     tx_payload_tlast <= skid_last;
                     skid_valid       <= pend;
                     if (pend) begin
                        skid_data <= ram_q;
                        skid_last <= pend_last;
                     end
                  end else if (pend) begin
                     tx_payload_tdata <= ram_q;
                     tx_payload_tlast <= pend_last;
                  end else begin
                     tx_payload_tvalid <= 1'b0;
                  end
               end else if (pend) begin
                  if (!tx_payload_tvalid) begin
                     tx_payload_tvalid <= 1'b1;
                     tx_payload_tdata  <= ram_q;
                     tx_payload_tlast  <= pend_last;
                  end else begin
                     skid_valid <= 1'b1;
                     skid_data  <= ram_q;
                     skid_last  <= pend_last;
                  end
               end
               if (pop && tx_payload_tlast) begin
                  tx_payload_tvalid <= 1'b0;
                  tx_payload_tlast  <= 1'b0;
                  skid_valid        <= 1'b0;
                  pend              <= 1'b0;
                  echo_count        <= echo_count + 1;
                  rx_hdr_ready      <= 1'b1;
                  state             <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_echo_buffered.sv
// tb/tb_udp_echo_buffered.sv - directed self-checking bench for udp_echo_buffered
module tb_udp_echo_buffered;

   localparam int BB = 128;
   localparam logic [31:0] LOCAL_IP = 32'hC0A80001;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] local_ip;
   logic        echo_enable;
   logic        rx_hdr_valid, rx_hdr_ready;
   logic [31:0] rx_hdr_ip_source_ip;
   logic [15:0] rx_hdr_source_port, rx_hdr_dest_port, rx_hdr_length;
   logic [7:0]  rx_payload_tdata;
   logic        rx_payload_tvalid, rx_payload_tready, rx_payload_tlast, rx_payload_tuser;
   logic        tx_hdr_valid, tx_hdr_ready;
   logic [31:0] tx_hdr_ip_source_ip, tx_hdr_ip_dest_ip;
   logic [7:0]  tx_hdr_ip_ttl;
   logic [5:0]  tx_hdr_ip_dscp;
   logic [1:0]  tx_hdr_ip_ecn;
   logic [15:0] tx_hdr_source_port, tx_hdr_dest_port, tx_hdr_length, tx_hdr_checksum;
   logic [7:0]  tx_payload_tdata;
   logic        tx_payload_tvalid, tx_payload_tready, tx_payload_tlast, tx_payload_tuser;
   logic [31:0] echo_count, drop_count;

   int errors = 0;
   int checks = 0;
   int exp_echo = 0;
   int exp_drop = 0;

   always #5 clk = ~clk;

   udp_echo_buffered #(.UDP_PORT(1230), .BUFFER_BYTES(BB), .TTL(64)) dut (
      .clk(clk), .reset(reset), .local_ip(local_ip), .echo_enable(echo_enable),
      .rx_hdr_valid(rx_hdr_valid), .rx_hdr_ready(rx_hdr_ready),
      .rx_hdr_ip_source_ip(rx_hdr_ip_source_ip), .rx_hdr_source_port(rx_hdr_source_port),
      .rx_hdr_dest_port(rx_hdr_dest_port), .rx_hdr_length(rx_hdr_length),
      .rx_payload_tdata(rx_payload_tdata), .rx_payload_tvalid(rx_payload_tvalid),
      .rx_payload_tready(rx_payload_tready), .rx_payload_tlast(rx_payload_tlast),
      .rx_payload_tuser(rx_payload_tuser),
      .tx_hdr_valid(tx_hdr_valid), .tx_hdr_ready(tx_hdr_ready),
      .tx_hdr_ip_source_ip(tx_hdr_ip_source_ip), .tx_hdr_ip_dest_ip(tx_hdr_ip_dest_ip),
      .tx_hdr_ip_ttl(tx_hdr_ip_ttl), .tx_hdr_ip_dscp(tx_hdr_ip_dscp), .tx_hdr_ip_ecn(tx_hdr_ip_ecn),
      .tx_hdr_source_port(tx_hdr_source_port), .tx_hdr_dest_port(tx_hdr_dest_port),
      .tx_hdr_length(tx_hdr_length), .tx_hdr_checksum(tx_hdr_checksum),
      .tx_payload_tdata(tx_payload_tdata), .tx_payload_tvalid(tx_payload_tvalid),
      .tx_payload_tready(tx_payload_tready), .tx_payload_tlast(tx_payload_tlast),
      .tx_payload_tuser(tx_payload_tuser),
      .echo_count(echo_count), .drop_count(drop_count)
   );

   task automatic send_header(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                              input int nbytes);
      int t = 0;
      rx_hdr_ip_source_ip = ip;
      rx_hdr_source_port  = sp;
      rx_hdr_dest_port    = dp;
      rx_hdr_length       = 16'(nbytes + 8);
      rx_hdr_valid        = 1'b1;
      forever begin
         @(negedge clk);
         if (rx_hdr_ready) begin
            @(posedge clk); #1;
            break;
         end
         t++;
         if (t > 200) begin
            errors++; checks++;
            $display("FAIL rx_hdr_timeout: rx_hdr_ready stayed 0 for %0d cycles", t);
            break;
         end
      end
      rx_hdr_valid = 1'b0;
      checks++;
      if (rx_payload_tready !== 1'b1) begin
         errors++;
         $display("FAIL rx_tready_after_hdr: got %b want 1", rx_payload_tready);
      end
   endtask

   task automatic send_payload(input logic [7:0] d[$], input bit bad, input int toggle_at);
      int t;
      for (int i = 0; i < d.size(); i++) begin
         rx_payload_tdata  = d[i];
         rx_payload_tlast  = (i == d.size() - 1);
         rx_payload_tuser  = bad && (i == d.size() - 1);
         rx_payload_tvalid = 1'b1;
         if (i == toggle_at) echo_enable = 1'b1;
         t = 0;
         forever begin
            @(negedge clk);
            if (rx_payload_tready) begin
               @(posedge clk); #1;
               break;
            end
            t++;
            if (t > 200) break;
         end
         if (t > 200) begin
            errors++; checks++;
            $display("FAIL rx_beat_timeout: beat %0d not accepted", i);
            break;
         end
      end
      rx_payload_tvalid = 1'b0;
      rx_payload_tlast  = 1'b0;
      rx_payload_tuser  = 1'b0;
   endtask

   task automatic recv_header(input logic [31:0] ip, input logic [15:0] port, input logic [15:0] len);
      int t = 0;
      logic [15:0] len0;
      tx_hdr_ready = 1'b0;
      @(negedge clk);
      while (!tx_hdr_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!tx_hdr_valid) begin
         errors++;
         $display("FAIL tx_hdr_timeout: tx_hdr_valid=%b want 1", tx_hdr_valid);
      end
      len0 = tx_hdr_length;
      @(negedge clk);
      checks++;
      if (tx_hdr_valid !== 1'b1 || tx_hdr_length !== len0) begin
         errors++;
         $display("FAIL tx_hdr_stable: valid=%b len=%0d want 1/%0d", tx_hdr_valid, tx_hdr_length, len0);
      end
      checks++;
      if (tx_hdr_ip_dest_ip !== ip || tx_hdr_dest_port !== port) begin
         errors++;
         $display("FAIL tx_hdr_dest: got %h:%0d want %h:%0d", tx_hdr_ip_dest_ip, tx_hdr_dest_port, ip, port);
      end
      checks++;
      if (tx_hdr_ip_source_ip !== LOCAL_IP || tx_hdr_source_port !== 16'd1230) begin
         errors++;
         $display("FAIL tx_hdr_src: got %h:%0d want %h:1230", tx_hdr_ip_source_ip, tx_hdr_source_port, LOCAL_IP);
      end
      checks++;
      if (tx_hdr_length !== len || tx_hdr_checksum !== 16'd0) begin
         errors++;
         $display("FAIL tx_hdr_len: got len=%0d csum=%h want %0d/0000", tx_hdr_length, tx_hdr_checksum, len);
      end
      checks++;
      if (tx_hdr_ip_ttl !== 8'd64 || tx_hdr_ip_dscp !== 6'd0 || tx_hdr_ip_ecn !== 2'd0) begin
         errors++;
         $display("FAIL tx_hdr_ip: got ttl=%0d dscp=%0d ecn=%0d want 64/0/0", tx_hdr_ip_ttl, tx_hdr_ip_dscp, tx_hdr_ip_ecn);
      end
      checks++;
      if (rx_hdr_ready !== 1'b0 || rx_payload_tready !== 1'b0) begin
         errors++;
         $display("FAIL rx_bp_hdr: got hdr_ready=%b tready=%b want 0/0", rx_hdr_ready, rx_payload_tready);
      end
      tx_hdr_ready = 1'b1;
      @(posedge clk); #1;
      tx_hdr_ready = 1'b0;
   endtask

   task automatic recv_payload(input logic [7:0] d[$], input bit rnd, input int max_beats);
      int idx = 0, cyc = 0, first = -1, lim;
      logic held_v = 1'b0;
      logic [7:0] held_d = '0;
      lim = (max_beats < d.size()) ? max_beats : d.size();
      while (idx < lim && cyc < 2000) begin
         tx_payload_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (tx_payload_tvalid) begin
            if (first < 0) begin
               first = cyc;
               checks++;
               if (first > 1) begin
                  errors++;
                  $display("FAIL tx_first_latency: got %0d cycles after handshake cycle want <=2", first + 1);
               end
            end
            if (held_v) begin
               checks++;
               if (tx_payload_tdata !== held_d) begin
                  errors++;
                  $display("FAIL tx_stall_stable: got %h want %h", tx_payload_tdata, held_d);
               end
            end
            if (tx_payload_tready) begin
               checks++;
               if (tx_payload_tdata !== d[idx] || tx_payload_tlast !== (idx == d.size() - 1)) begin
                  errors++;
                  $display("FAIL tx_byte[%0d]: got %h last=%b want %h last=%b", idx, tx_payload_tdata,
                           tx_payload_tlast, d[idx], (idx == d.size() - 1));
               end
               idx++;
               held_v = 1'b0;
            end else begin
               held_v = 1'b1;
               held_d = tx_payload_tdata;
            end
         end else if (!rnd && first >= 0) begin
            checks++; errors++;
            $display("FAIL tx_bubble: tvalid=0 at byte %0d want 1", idx);
         end
         if (first >= 0) begin
            checks++;
            if (rx_hdr_ready !== 1'b0 || rx_payload_tready !== 1'b0) begin
               errors++;
               $display("FAIL rx_bp_payload: got hdr_ready=%b tready=%b want 0/0", rx_hdr_ready, rx_payload_tready);
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      tx_payload_tready = 1'b0;
      checks++;
      if (idx != lim) begin
         errors++;
         $display("FAIL tx_payload_timeout: got %0d bytes want %0d", idx, lim);
      end
      if (lim == d.size()) begin
         checks++;
         if (tx_payload_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL tx_extra_beat: tvalid=%b after tlast want 0", tx_payload_tvalid);
         end
      end
   endtask

   task automatic check_idle_counts(input string name);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (echo_count !== 32'(exp_echo) || drop_count !== 32'(exp_drop)) begin
         errors++;
         $display("FAIL %s_counts: got echo=%0d drop=%0d want %0d/%0d", name, echo_count, drop_count,
                  exp_echo, exp_drop);
      end
      checks++;
      if (tx_hdr_valid !== 1'b0 || tx_payload_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL %s_tx_quiet: got hdr_valid=%b tvalid=%b want 0/0", name, tx_hdr_valid, tx_payload_tvalid);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rx_hdr_ready !== 1'b0 || rx_payload_tready !== 1'b0 || tx_hdr_valid !== 1'b0 || tx_payload_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshakes: got %b%b%b%b want 0000", rx_hdr_ready, rx_payload_tready, tx_hdr_valid, tx_payload_tvalid);
      end
      checks++;
      if (echo_count !== 32'd0 || drop_count !== 32'd0 || tx_hdr_length !== 16'd0 || tx_payload_tdata !== 8'd0) begin
         errors++;
         $display("FAIL reset_values: got echo=%0d drop=%0d len=%0d tdata=%h want 0", echo_count, drop_count, tx_hdr_length, tx_payload_tdata);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (rx_hdr_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", rx_hdr_ready);
      end
   endtask

   task automatic test_basic;
      logic [7:0] d[$];
      d = {8'h01, 8'h02, 8'h03, 8'h04};
      send_header(32'h0A000002, 16'd5000, 16'd1230, 4);
      send_payload(d, 1'b0, -1);
      checks++;
      if (tx_hdr_valid !== 1'b1) begin
         errors++;
         $display("FAIL tx_hdr_latency: got %b want 1 the cycle after last rx beat", tx_hdr_valid);
      end
      recv_header(32'h0A000002, 16'd5000, 16'd12);
      recv_payload(d, 1'b0, 1 << 30);
      exp_echo++;
      check_idle_counts("basic");
   endtask

   task automatic test_wrong_port;
      logic [7:0] d[$];
      for (int i = 0; i < 10; i++) d.push_back(8'(8'h30 + i));
      send_header(32'h0A000003, 16'd5001, 16'd1231, 10);
      send_payload(d, 1'b0, -1);
      exp_drop++;
      check_idle_counts("wrong_port");
      d = {8'hAA, 8'hBB, 8'hCC};
      send_header(32'h0A000007, 16'd6000, 16'd1230, 3);
      send_payload(d, 1'b0, -1);
      recv_header(32'h0A000007, 16'd6000, 16'd11);
      recv_payload(d, 1'b0, 1 << 30);
      exp_echo++;
      check_idle_counts("after_drop");
   endtask

   task automatic test_bad_frame;
      logic [7:0] d[$];
      for (int i = 0; i < 6; i++) d.push_back(8'(8'h50 + i));
      send_header(32'h0A000002, 16'd5000, 16'd1230, 6);
      send_payload(d, 1'b1, -1);
      exp_drop++;
      check_idle_counts("bad_frame");
   endtask

   task automatic test_overflow;
      logic [7:0] d[$];
      for (int i = 0; i < BB + 1; i++) d.push_back(8'(i));
      send_header(32'h0A000002, 16'd5000, 16'd1230, BB + 1);
      send_payload(d, 1'b0, -1);
      exp_drop++;
      check_idle_counts("overflow");
   endtask

   task automatic test_full;
      logic [7:0] d[$];
      for (int i = 0; i < BB; i++) d.push_back(8'(255 - i));
      send_header(32'h0A000009, 16'd7000, 16'd1230, BB);
      send_payload(d, 1'b0, -1);
      recv_header(32'h0A000009, 16'd7000, 16'(BB + 8));
      recv_payload(d, 1'b0, 1 << 30);
      exp_echo++;
      check_idle_counts("full");
   endtask

   task automatic test_backpressure;
      logic [7:0] d[$];
      for (int i = 0; i < 100; i++) d.push_back(8'(i * 7 + 3));
      send_header(32'h0A000004, 16'd4000, 16'd1230, 100);
      send_payload(d, 1'b0, -1);
      recv_header(32'h0A000004, 16'd4000, 16'd108);
      recv_payload(d, 1'b1, 1 << 30);
      exp_echo++;
      check_idle_counts("backpressure");
   endtask

   task automatic test_enable;
      logic [7:0] d[$];
      for (int i = 0; i < 8; i++) d.push_back(8'(8'h70 + i));
      echo_enable = 1'b0;
      send_header(32'h0A000002, 16'd5000, 16'd1230, 8);
      send_payload(d, 1'b0, 3);
      exp_drop++;
      check_idle_counts("enable");
   endtask

   task automatic test_reset_mid_tx;
      logic [7:0] d[$];
      for (int i = 0; i < 20; i++) d.push_back(8'(8'h90 + i));
      send_header(32'h0A000005, 16'd5500, 16'd1230, 20);
      send_payload(d, 1'b0, -1);
      recv_header(32'h0A000005, 16'd5500, 16'd28);
      recv_payload(d, 1'b0, 5);
      tx_payload_tready = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (tx_payload_tvalid !== 1'b0 || tx_payload_tlast !== 1'b0 || tx_payload_tdata !== 8'd0 || rx_hdr_ready !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_outputs: got tvalid=%b tlast=%b tdata=%h hdr_ready=%b want 0", tx_payload_tvalid,
                  tx_payload_tlast, tx_payload_tdata, rx_hdr_ready);
      end
      checks++;
      if (echo_count !== 32'd0 || drop_count !== 32'd0) begin
         errors++;
         $display("FAIL async_reset_counts: got echo=%0d drop=%0d want 0/0", echo_count, drop_count);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      exp_echo = 0;
      exp_drop = 0;
      d = {8'h11, 8'h22};
      send_header(32'h0A000006, 16'd6600, 16'd1230, 2);
      send_payload(d, 1'b0, -1);
      recv_header(32'h0A000006, 16'd6600, 16'd10);
      recv_payload(d, 1'b0, 1 << 30);
      exp_echo++;
      check_idle_counts("after_reset");
   endtask

   initial begin
      reset               = 1'b1;
      local_ip            = LOCAL_IP;
      echo_enable         = 1'b1;
      rx_hdr_valid        = 1'b0;
      rx_hdr_ip_source_ip = '0;
      rx_hdr_source_port  = '0;
      rx_hdr_dest_port    = '0;
      rx_hdr_length       = '0;
      rx_payload_tdata    = '0;
      rx_payload_tvalid   = 1'b0;
      rx_payload_tlast    = 1'b0;
      rx_payload_tuser    = 1'b0;
      tx_hdr_ready        = 1'b0;
      tx_payload_tready   = 1'b0;
      test_reset();
      test_basic();
      test_wrong_port();
      test_bad_frame();
      test_overflow();
      test_full();
      test_backpressure();
      test_enable();
      test_reset_mid_tx();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
